// File: rtl/imuldiv_div_requester.sv
// -----------------------------------------------------------------------------
// imuldiv_div_requester
//
// Initiator side of the divider val/rdy protocol. Requests from the execute
// stage pass straight through to the iterative divider. Each accepted request
// leaves {sel, tag} in a small in-order FIFO. When the divider answers, the
// matching entry picks the quotient or remainder half. That half is returned
// on a registered response port together with the destination tag.
//
// Ports
//   clk, reset              rising-edge clock, async active-low reset
//   cpureq_msg_*            fn (signed), sel (0 quotient / 1 remainder),
//                           a, b, tag of the CPU-side request
//   cpureq_val/cpureq_rdy   CPU request handshake
//   divreq_msg_*            fn, a, b to the divider (combinational)
//   divreq_val/divreq_rdy   divider request handshake
//   divresp_msg_result      {remainder, quotient} from the divider
//   divresp_val/divresp_rdy divider response handshake
//   cpuresp_msg_data/tag    registered selected result half and tag
//   cpuresp_val/cpuresp_rdy CPU response handshake
// -----------------------------------------------------------------------------
module imuldiv_div_requester #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpureq_msg_fn,
    input  logic             cpureq_msg_sel,
    input  logic [31:0]      cpureq_msg_a,
    input  logic [31:0]      cpureq_msg_b,
    input  logic [TAG_W-1:0] cpureq_msg_tag,
    input  logic             cpureq_val,
    output logic             cpureq_rdy,
    output logic             divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,
    output logic [31:0]      cpuresp_msg_data,
    output logic [TAG_W-1:0] cpuresp_msg_tag,
    output logic             cpuresp_val,
    input  logic             cpuresp_rdy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Outstanding-operation bookkeeping
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             sel_mem_q [DEPTH];
    logic             sel_mem_d [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_d [DEPTH];

    // Registered response port
    logic             out_val_q, out_val_d;
    logic [31:0]      data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             full_s;
    logic             empty_s;
    logic             req_fire_s;
    logic             resp_fire_s;
    logic             head_sel_s;
    logic [TAG_W-1:0] head_tag_s;

    // Full is taken from the registered count only, so a pop in the same
    // cycle never opens cpureq_rdy combinationally.
    assign full_s      = (count_q == CNT_FULL);
    assign empty_s     = (count_q == CNT_ZERO);

    assign divreq_msg_fn = cpureq_msg_fn;
    assign divreq_msg_a  = cpureq_msg_a;
    assign divreq_msg_b  = cpureq_msg_b;
    assign divreq_val    = cpureq_val & ~full_s;
    assign cpureq_rdy    = divreq_rdy & ~full_s;
    assign req_fire_s    = cpureq_val & cpureq_rdy;

    // A response is taken only when something is outstanding and the output
    // register is free or draining this cycle.
    assign divresp_rdy   = ~empty_s & (~out_val_q | cpuresp_rdy);
    assign resp_fire_s   = divresp_val & divresp_rdy;

    assign head_sel_s    = sel_mem_q[head_q];
    assign head_tag_s    = tag_mem_q[head_q];

    assign cpuresp_val      = out_val_q;
    assign cpuresp_msg_data = data_q;
    assign cpuresp_msg_tag  = tag_q;

    // Tag FIFO write side: capture {sel, tag} at the tail on each accepted request
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel_mem_d[i] = sel_mem_q[i];
            tag_mem_d[i] = tag_mem_q[i];
        end
        if (req_fire_s) begin
            sel_mem_d[tail_q] = cpureq_msg_sel;
            tag_mem_d[tail_q] = cpureq_msg_tag;
            tail_d            = tail_q + PTR_ONE;
        end else begin
            tail_d            = tail_q;
        end
    end

    // Occupancy counter and head pointer: simultaneous push and pop cancel
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (resp_fire_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        if (req_fire_s && !resp_fire_s) begin
            count_d = count_q + CNT_ONE;
        end else if (resp_fire_s && !req_fire_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Response register: load the selected half on a divider response, drop
    // valid after a CPU handshake, otherwise hold data and tag steady.
    always_comb begin
        out_val_d = out_val_q;
        data_d    = data_q;
        tag_d     = tag_q;
        if (resp_fire_s) begin
            out_val_d = 1'b1;
            data_d    = head_sel_s ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
            tag_d     = head_tag_s;
        end else if (out_val_q && cpuresp_rdy) begin
            out_val_d = 1'b0;
        end else begin
            out_val_d = out_val_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= CNT_ZERO;
            head_q    <= '0;
            tail_q    <= '0;
            out_val_q <= 1'b0;
            data_q    <= 32'h0000_0000;
            tag_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sel_mem_q[i] <= 1'b0;
                tag_mem_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            out_val_q <= out_val_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            for (int i = 0; i < DEPTH; i++) begin
                sel_mem_q[i] <= sel_mem_d[i];
                tag_mem_q[i] <= tag_mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_imuldiv_div_requester.sv
// -----------------------------------------------------------------------------
// Bench for imuldiv_div_requester.
//
// A divider stand-in computes each accepted operation with plain arithmetic.
// The expected CPU response is queued when the request is accepted. A
// negedge monitor pops that queue on every CPU response handshake. It also
// checks the handshake signals against the outstanding count held in the
// bench's divider queue.
// -----------------------------------------------------------------------------
module tb_imuldiv_div_requester;

    localparam int TAG_W = 5;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpureq_msg_fn;
    logic             cpureq_msg_sel;
    logic [31:0]      cpureq_msg_a;
    logic [31:0]      cpureq_msg_b;
    logic [TAG_W-1:0] cpureq_msg_tag;
    logic             cpureq_val;
    logic             cpureq_rdy;
    logic             divreq_msg_fn;
    logic [31:0]      divreq_msg_a;
    logic [31:0]      divreq_msg_b;
    logic             divreq_val;
    logic             divreq_rdy;
    logic [63:0]      divresp_msg_result;
    logic             divresp_val;
    logic             divresp_rdy;
    logic [31:0]      cpuresp_msg_data;
    logic [TAG_W-1:0] cpuresp_msg_tag;
    logic             cpuresp_val;
    logic             cpuresp_rdy;

    int total = 0;
    int bad   = 0;

    logic [63:0]       dq[$];      // results the divider still owes
    logic [TAG_W+31:0] exp_q[$];   // expected {tag, data} in request order
    logic              m_out_val;  // model: response register holds a result
    logic              stall_prev;
    logic [31:0]       prev_data;
    logic [TAG_W-1:0]  prev_tag;

    imuldiv_div_requester #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .cpureq_msg_fn      (cpureq_msg_fn),
        .cpureq_msg_sel     (cpureq_msg_sel),
        .cpureq_msg_a       (cpureq_msg_a),
        .cpureq_msg_b       (cpureq_msg_b),
        .cpureq_msg_tag     (cpureq_msg_tag),
        .cpureq_val         (cpureq_val),
        .cpureq_rdy         (cpureq_rdy),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy),
        .cpuresp_msg_data   (cpuresp_msg_data),
        .cpuresp_msg_tag    (cpuresp_msg_tag),
        .cpuresp_val        (cpuresp_val),
        .cpuresp_rdy        (cpuresp_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference divider: quotient/remainder with RISC-V style corner cases
    function automatic logic [63:0] div_model(input logic fn, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (fn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (fn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            dq.delete();
            exp_q.delete();
            m_out_val  = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("pass_fn", {63'd0, divreq_msg_fn}, {63'd0, cpureq_msg_fn});
            chk("pass_a", {32'd0, divreq_msg_a}, {32'd0, cpureq_msg_a});
            chk("pass_b", {32'd0, divreq_msg_b}, {32'd0, cpureq_msg_b});
            chk("divreq_val", {63'd0, divreq_val},
                {63'd0, cpureq_val && (dq.size() < DEPTH)});
            chk("cpureq_rdy", {63'd0, cpureq_rdy},
                {63'd0, divreq_rdy && (dq.size() < DEPTH)});
            chk("divresp_rdy", {63'd0, divresp_rdy},
                {63'd0, (dq.size() != 0) && (!m_out_val || cpuresp_rdy)});
            chk("cpuresp_val", {63'd0, cpuresp_val}, {63'd0, m_out_val});
            if (stall_prev) begin
                chk("stall_data", {32'd0, cpuresp_msg_data}, {32'd0, prev_data});
                chk("stall_tag", {59'd0, cpuresp_msg_tag}, {59'd0, prev_tag});
            end
            if (cpuresp_val && cpuresp_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [TAG_W+31:0] e;
                    e = exp_q.pop_front();
                    chk("resp_data", {32'd0, cpuresp_msg_data}, {32'd0, e[31:0]});
                    chk("resp_tag", {59'd0, cpuresp_msg_tag}, {59'd0, e[TAG_W+31:32]});
                end
            end
            if (divresp_val && divresp_rdy) begin
                if (dq.size() == 0) begin
                    chk("divresp_accept_empty", 64'd1, 64'd0);
                end else begin
                    void'(dq.pop_front());
                end
                m_out_val = 1'b1;
            end else if (m_out_val && cpuresp_rdy) begin
                m_out_val = 1'b0;
            end
            if (cpureq_val && cpureq_rdy) begin
                logic [63:0] r;
                r = div_model(cpureq_msg_fn, cpureq_msg_a, cpureq_msg_b);
                dq.push_back(r);
                exp_q.push_back({cpureq_msg_tag, cpureq_msg_sel ? r[63:32] : r[31:0]});
            end
            stall_prev = cpuresp_val && !cpuresp_rdy;
            prev_data  = cpuresp_msg_data;
            prev_tag   = cpuresp_msg_tag;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic fn, input logic sel, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag);
        cpureq_val     = 1'b1;
        cpureq_msg_fn  = fn;
        cpureq_msg_sel = sel;
        cpureq_msg_a   = a;
        cpureq_msg_b   = b;
        cpureq_msg_tag = tag;
    endtask

    task automatic drive_head();
        divresp_msg_result = (dq.size() != 0) ? dq[0] : 64'h0BAD_0BAD_0BAD_0BAD;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        cpureq_val = 1'b0; cpureq_msg_fn = 1'b0; cpureq_msg_sel = 1'b0;
        cpureq_msg_a = 32'd0; cpureq_msg_b = 32'd0; cpureq_msg_tag = '0;
        divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = 64'd0;
        cpuresp_rdy = 1'b0;
        #2;
        chk("rst_cpuresp_val", {63'd0, cpuresp_val}, 64'd0);
        chk("rst_data", {32'd0, cpuresp_msg_data}, 64'd0);
        chk("rst_tag", {59'd0, cpuresp_msg_tag}, 64'd0);
        chk("rst_divresp_rdy", {63'd0, divresp_rdy}, 64'd0);
        cyc(); cyc();
        reset = 1'b1;
        divreq_rdy = 1'b1;
        cpuresp_rdy = 1'b1;
        cyc();

        // Signed quotient 7/2
        set_req(1'b1, 1'b0, 32'd7, 32'd2, 5'd3);
        #1 chk("t1_cpureq_rdy", {63'd0, cpureq_rdy}, 64'd1);
        cyc();
        cpureq_val = 1'b0;
        divresp_val = 1'b1;
        divresp_msg_result = {32'd1, 32'd3};
        #1 chk("t1_divresp_rdy", {63'd0, divresp_rdy}, 64'd1);
        chk("t1_not_early", {63'd0, cpuresp_val}, 64'd0);
        cyc();
        divresp_val = 1'b0;
        #1 chk("t1_val", {63'd0, cpuresp_val}, 64'd1);
        chk("t1_data", {32'd0, cpuresp_msg_data}, 64'h3);
        chk("t1_tag", {59'd0, cpuresp_msg_tag}, 64'd3);
        cyc();
        #1 chk("t1_drained", {63'd0, cpuresp_val}, 64'd0);

        // Signed remainder -7 % 2
        set_req(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd9);
        cyc();
        cpureq_val = 1'b0;
        divresp_val = 1'b1;
        divresp_msg_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        cyc();
        divresp_val = 1'b0;
        #1 chk("t2_data", {32'd0, cpuresp_msg_data}, 64'hFFFF_FFFF);
        chk("t2_tag", {59'd0, cpuresp_msg_tag}, 64'd9);
        cyc();

        // Full boundary and ordering with tags 1, 2, 3
        set_req(1'b0, 1'b0, 32'd50, 32'd5, 5'd1);
        #1 chk("t3_rdy1", {63'd0, cpureq_rdy}, 64'd1);
        cyc();
        set_req(1'b0, 1'b1, 32'd51, 32'd5, 5'd2);
        #1 chk("t3_rdy2", {63'd0, cpureq_rdy}, 64'd1);
        cyc();
        set_req(1'b1, 1'b0, 32'hFFFF_FF00, 32'd16, 5'd3);
        #1 chk("t3_full_rdy", {63'd0, cpureq_rdy}, 64'd0);
        chk("t3_full_val", {63'd0, divreq_val}, 64'd0);
        cyc();
        #1 chk("t3_still_full", {63'd0, cpureq_rdy}, 64'd0);
        divresp_val = 1'b1;
        drive_head();
        #1 chk("t3_no_comb_path", {63'd0, cpureq_rdy}, 64'd0);
        cyc();
        divresp_val = 1'b0;
        #1 chk("t3_rdy_after_pop", {63'd0, cpureq_rdy}, 64'd1);
        cyc();
        cpureq_val = 1'b0;
        for (int i = 0; i < 10 && dq.size() != 0; i++) begin
            divresp_val = 1'b1;
            drive_head();
            cyc();
        end
        divresp_val = 1'b0;
        cyc();
        chk("t3_all_out", {32'd0, 32'(exp_q.size())}, 64'd0);

        // Response backpressure
        cpuresp_rdy = 1'b0;
        set_req(1'b0, 1'b0, 32'd100, 32'd7, 5'd4);
        cyc();
        set_req(1'b0, 1'b1, 32'd100, 32'd7, 5'd5);
        cyc();
        cpureq_val = 1'b0;
        divresp_val = 1'b1;
        drive_head();
        cyc();
        drive_head();
        for (int i = 0; i < 5; i++) begin
            #1 chk("t4_stall_rdy", {63'd0, divresp_rdy}, 64'd0);
            chk("t4_stall_val", {63'd0, cpuresp_val}, 64'd1);
            chk("t4_stall_data", {32'd0, cpuresp_msg_data}, 64'd14);
            chk("t4_stall_tag", {59'd0, cpuresp_msg_tag}, 64'd4);
            cyc();
        end
        cpuresp_rdy = 1'b1;
        #1 chk("t4_release_rdy", {63'd0, divresp_rdy}, 64'd1);
        cyc();
        divresp_val = 1'b0;
        #1 chk("t4_second_val", {63'd0, cpuresp_val}, 64'd1);
        chk("t4_second_data", {32'd0, cpuresp_msg_data}, 64'd2);
        chk("t4_second_tag", {59'd0, cpuresp_msg_tag}, 64'd5);
        cyc();

        // Empty guard
        divresp_val = 1'b1;
        divresp_msg_result = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t5_empty_rdy", {63'd0, divresp_rdy}, 64'd0);
            chk("t5_empty_val", {63'd0, cpuresp_val}, 64'd0);
            cyc();
        end
        divresp_val = 1'b0;

        // Asynchronous reset with count=2 and out_val=1
        cpuresp_rdy = 1'b0;
        set_req(1'b0, 1'b0, 32'd9, 32'd3, 5'd6);
        cyc();
        set_req(1'b0, 1'b0, 32'd9, 32'd4, 5'd7);
        cyc();
        cpureq_val = 1'b0;
        divresp_val = 1'b1;
        drive_head();
        cyc();
        divresp_val = 1'b0;
        set_req(1'b0, 1'b1, 32'd9, 32'd5, 5'd8);
        cyc();
        cpureq_val = 1'b0;
        #1 chk("t6_pre_val", {63'd0, cpuresp_val}, 64'd1);
        #1 reset = 1'b0;
        #1 chk("t6_async_val", {63'd0, cpuresp_val}, 64'd0);
        chk("t6_async_data", {32'd0, cpuresp_msg_data}, 64'd0);
        chk("t6_async_tag", {59'd0, cpuresp_msg_tag}, 64'd0);
        cyc(); cyc();
        reset = 1'b1;
        divreq_rdy = 1'b0;
        #1 chk("t6_rdy_follow0", {63'd0, cpureq_rdy}, 64'd0);
        divreq_rdy = 1'b1;
        #1 chk("t6_rdy_follow1", {63'd0, cpureq_rdy}, 64'd1);
        divresp_val = 1'b1;
        divresp_msg_result = 64'hDEAD_BEEF_CAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t6_stale_rdy", {63'd0, divresp_rdy}, 64'd0);
            chk("t6_stale_val", {63'd0, cpuresp_val}, 64'd0);
            cyc();
        end
        divresp_val = 1'b0;
        cpuresp_rdy = 1'b1;
        cyc();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b,
                    TAG_W'($urandom));
            cpureq_val  = ($urandom_range(0, 1) == 1);
            divreq_rdy  = ($urandom_range(0, 3) != 0);
            divresp_val = ($urandom_range(0, 1) == 1);
            cpuresp_rdy = ($urandom_range(0, 9) < 7);
            drive_head();
            cyc();
        end

        // Drain remaining work
        cpureq_val  = 1'b0;
        cpuresp_rdy = 1'b1;
        for (int i = 0; i < 50 && (dq.size() != 0 || exp_q.size() != 0); i++) begin
            divresp_val = 1'b1;
            drive_head();
            cyc();
        end
        divresp_val = 1'b0;
        cyc();
        chk("drain_outstanding", {32'd0, 32'(dq.size())}, 64'd0);
        chk("drain_expected", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
